uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART transmitter with a small transmit FIFO.
// Bytes go out LSB first, with optional even parity and 1 or 2 stop bits.
module uart_tx #(
  parameter int BAUD_DIV   = 868,
  parameter int PARITY_EN  = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          arst_i,
  input  logic [7:0]                    tx_data_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [15:0] BAUD_LOAD = 16'(BAUD_DIV - 1);
  localparam logic LAST_STOP = (STOP_BITS == 2);
  localparam logic PAR_ON = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;

  logic [7:0]  shreg_q;
  logic [7:0]  shreg_d;
  logic        par_q;
  logic        par_d;
  logic [2:0]  bit_idx_q;
  logic [2:0]  bit_idx_d;
  logic        stop_idx_q;
  logic        stop_idx_d;
  logic [15:0] baud_q;
  logic [15:0] baud_d;
  logic        tx_q;
  logic        tx_d;

  logic       push;
  logic       pop;
  logic       tick;
  logic       fifo_ne;
  logic [7:0] head;

  assign fifo_ne    = (cnt_q != '0);
  assign tx_ready_o = (cnt_q != FULL);
  assign push       = tx_valid_i & tx_ready_o;
  assign head       = mem[rd_ptr_q];
  assign tick       = (baud_q == '0);

  assign tx_o       = tx_q;
  assign busy_o     = (state_q != IDLE) | fifo_ne;
  assign fifo_cnt_o = cnt_q;

  // Storage needs no reset; occupancy alone says what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_q] <= tx_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    baud_d     = baud_q;
    tx_d       = tx_q;
    pop        = 1'b0;

    if (state_q != IDLE && !tick) begin
      baud_d = baud_q - 16'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (fifo_ne) begin
          pop     = 1'b1;
          state_d = START;
          shreg_d = head;
          par_d   = ^head;
          baud_d  = BAUD_LOAD;
          tx_d    = 1'b0;
        end
      end

      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_idx_d = '0;
          baud_d    = BAUD_LOAD;
          tx_d      = shreg_q[0];
        end
      end

      DATA: begin
        if (tick) begin
          baud_d = BAUD_LOAD;
          if (bit_idx_q == 3'd7) begin
            if (PAR_ON) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d    = STOP;
              stop_idx_d = 1'b0;
              tx_d       = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shreg_d   = {1'b0, shreg_q[7:1]};
            tx_d      = shreg_q[1];
          end
        end
      end

      PARITY: begin
        if (tick) begin
          state_d    = STOP;
          stop_idx_d = 1'b0;
          baud_d     = BAUD_LOAD;
          tx_d       = 1'b1;
        end
      end

      STOP: begin
        if (tick) begin
          if (stop_idx_q != LAST_STOP) begin
            stop_idx_d = 1'b1;
            baud_d     = BAUD_LOAD;
          end else if (fifo_ne) begin
            // Chain straight into the next start bit.
            pop     = 1'b1;
            state_d = START;
            shreg_d = head;
            par_d   = ^head;
            baud_d  = BAUD_LOAD;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      baud_q     <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      baud_q     <= baud_d;
      tx_q       <= tx_d;
    end
  end

endmodule
